// File: rtl/i2c_xfer_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM engine among N_REQ requesters:
// grant, launch, watchdog abort, done/error return, then a bus-free gap.
module i2c_xfer_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 47
) (
    input  logic                 i_clk10MHz,
    input  logic                 i_RST,
    input  logic [N_REQ-1:0]     i_Req,
    input  logic [N_REQ-1:0]     i_Req_RW,
    input  logic [8*N_REQ-1:0]   i_Req_Addr,
    input  logic [4*N_REQ-1:0]   i_Req_Len,
    input  logic                 i_Eng_Busy,
    input  logic                 i_Eng_Done,
    input  logic                 i_Eng_Nack,
    output logic [N_REQ-1:0]     o_Grant,
    output logic                 o_Start,
    output logic                 o_RW,
    output logic [7:0]           o_Start_Addr,
    output logic [3:0]           o_Byte_Count,
    output logic                 o_Abort,
    output logic [N_REQ-1:0]     o_Done,
    output logic [N_REQ-1:0]     o_Err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_COMPLETE,
        S_GAP
    } state_t;

    state_t state, state_d;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] win_idx;
    logic          win_valid;
    logic [3:0]    win_len;
    logic [WW-1:0] wd_cnt;
    logic [GW-1:0] gap_cnt;
    logic          err, err_d;
    logic          abort_d, grant_d;
    logic          pend_done, pend_nack;
    logic          eng_fin, fin_nack;
    logic          wd_hit, gap_end;

    // Lowest rotation offset from rr_ptr wins; descending loop keeps the smallest.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_Req[IW'((int'(rr_ptr) + i) % N_REQ)]) begin
                win_valid = 1'b1;
                win_idx   = IW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign win_len = i_Req_Len[{win_idx, 2'b00} +: 4];

    // A done seen during LAUNCH is held and honoured in WAIT_BUSY.
    assign eng_fin  = i_Eng_Done | ((state == S_WAIT_BUSY) & pend_done);
    assign fin_nack = i_Eng_Done ? i_Eng_Nack : pend_nack;

    assign wd_hit  = (int'(wd_cnt) + 1) >= (TIMEOUT_CYCLES - 1);
    assign gap_end = (int'(gap_cnt) + 1) >= GAP_CYCLES;

    always_ff @(posedge i_clk10MHz or posedge i_RST) begin
        if (i_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        err_d   = err;
        abort_d = 1'b0;
        grant_d = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (win_valid) begin
                    grant_d = 1'b1;
                    if (win_len == 4'h0) begin
                        state_d = S_COMPLETE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                        err_d   = 1'b0;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_RUN: begin
                if (eng_fin) begin
                    state_d = S_COMPLETE;
                    err_d   = fin_nack;
                end else if (wd_hit) begin
                    state_d = S_COMPLETE;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                end else if (state == S_WAIT_BUSY && i_Eng_Busy) begin
                    state_d = S_RUN;
                end
            end
            S_COMPLETE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk10MHz or posedge i_RST) begin
        if (i_RST) begin
            rr_ptr       <= '0;
            idx          <= '0;
            err          <= 1'b0;
            pend_done    <= 1'b0;
            pend_nack    <= 1'b0;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
            o_Grant      <= '0;
            o_Start      <= 1'b0;
            o_RW         <= 1'b0;
            o_Start_Addr <= 8'h00;
            o_Byte_Count <= 4'h0;
            o_Abort      <= 1'b0;
            o_Done       <= '0;
            o_Err        <= '0;
        end else begin
            err     <= err_d;
            o_Start <= (state == S_LAUNCH);
            o_Abort <= abort_d;
            o_Done  <= '0;
            o_Err   <= '0;
            if (grant_d) begin
                idx          <= win_idx;
                o_Grant      <= N_REQ'(1) << win_idx;
                o_RW         <= i_Req_RW[win_idx];
                o_Start_Addr <= i_Req_Addr[{win_idx, 3'b000} +: 8];
                o_Byte_Count <= win_len;
            end
            if (state == S_COMPLETE) begin
                o_Done[idx] <= 1'b1;
                o_Err[idx]  <= err;
                o_Grant     <= '0;
                rr_ptr      <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
            end
            if (state == S_LAUNCH) begin
                pend_done <= i_Eng_Done;
                pend_nack <= i_Eng_Nack;
                wd_cnt    <= '0;
            end else if (state == S_WAIT_BUSY || state == S_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (state == S_COMPLETE) begin
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Scoreboard bench for i2c_xfer_arbiter: a round-robin list model predicts
// grant order and responses; a monitor checks every DUT event against it.
module tb_i2c_xfer_arbiter;
    localparam int N   = 4;
    localparam int TO  = 50000;
    localparam int GAP = 47;

    typedef struct {
        int mode;
        int bdly;
        int run;
        bit nack;
    } plan_t;

    typedef struct {
        int         idx;
        bit         rw;
        logic [7:0] addr;
        logic [3:0] len;
        bit         err;
        int         mode;
        bit         first;
    } exp_t;

    logic           i_clk10MHz = 1'b0;
    logic           i_RST;
    logic [N-1:0]   i_Req;
    logic [N-1:0]   i_Req_RW;
    logic [8*N-1:0] i_Req_Addr;
    logic [4*N-1:0] i_Req_Len;
    logic           i_Eng_Busy, i_Eng_Done, i_Eng_Nack;
    logic [N-1:0]   o_Grant;
    logic           o_Start, o_RW, o_Abort;
    logic [7:0]     o_Start_Addr;
    logic [3:0]     o_Byte_Count;
    logic [N-1:0]   o_Done, o_Err;

    i2c_xfer_arbiter #(
        .N_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
    ) dut (
        .i_clk10MHz  (i_clk10MHz),
        .i_RST       (i_RST),
        .i_Req       (i_Req),
        .i_Req_RW    (i_Req_RW),
        .i_Req_Addr  (i_Req_Addr),
        .i_Req_Len   (i_Req_Len),
        .i_Eng_Busy  (i_Eng_Busy),
        .i_Eng_Done  (i_Eng_Done),
        .i_Eng_Nack  (i_Eng_Nack),
        .o_Grant     (o_Grant),
        .o_Start     (o_Start),
        .o_RW        (o_RW),
        .o_Start_Addr(o_Start_Addr),
        .o_Byte_Count(o_Byte_Count),
        .o_Abort     (o_Abort),
        .o_Done      (o_Done),
        .o_Err       (o_Err)
    );

    always #50 i_clk10MHz = ~i_clk10MHz;

    int cyc = 0;
    always @(posedge i_clk10MHz) cyc <= cyc + 1;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    plan_t eng_q[$];
    int    model_rr = 0;
    int    req_cyc = 0;
    int    eng_done_cyc = 0;

    bit         rw_a[N];
    logic [7:0] addr_a[N];
    logic [3:0] len_a[N];
    plan_t      plan_a[N];
    bit         drop_a[N];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    task automatic set_req(input int k, input bit rw, input logic [7:0] a,
                           input logic [3:0] l, input int mode, input int bdly,
                           input int run, input bit nack);
        rw_a[k]   = rw;
        addr_a[k] = a;
        len_a[k]  = l;
        plan_a[k] = '{mode: mode, bdly: bdly, run: run, nack: nack};
        drop_a[k] = bit'($urandom % 2);
    endtask

    task automatic rand_req(input int k);
        logic [3:0] l;
        int mode;
        l = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        mode = ($urandom % 4 == 0) ? 1 : 0;
        set_req(k, bit'($urandom % 2), 8'($urandom), l, mode,
                $urandom_range(0, 3), $urandom_range(1, 30),
                ($urandom % 4 == 0));
    endtask

    // Model: with requests held, each winner is the next pending requester at
    // or after the pointer; the pointer then moves just past that winner.
    task automatic issue_round(input logic [N-1:0] mask);
        logic [N-1:0] rem;
        int ptr;
        bit first;
        exp_t e;
        rem = mask;
        ptr = model_rr;
        first = 1'b1;
        while (rem != 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (ptr + i) % N;
                if (rem[k]) begin
                    e.idx   = k;
                    e.rw    = rw_a[k];
                    e.addr  = addr_a[k];
                    e.len   = len_a[k];
                    e.mode  = (len_a[k] == 0) ? -1 : plan_a[k].mode;
                    e.err   = (len_a[k] == 0) || (plan_a[k].mode == 2) ||
                              plan_a[k].nack;
                    e.first = first;
                    first   = 1'b0;
                    exp_q.push_back(e);
                    if (len_a[k] != 0) eng_q.push_back(plan_a[k]);
                    rem[k] = 1'b0;
                    ptr = (k + 1) % N;
                    break;
                end
            end
        end
        model_rr = ptr;
        @(posedge i_clk10MHz);
        #1;
        for (int k = 0; k < N; k++) begin
            i_Req_RW[k]          = rw_a[k];
            i_Req_Addr[8*k +: 8] = addr_a[k];
            i_Req_Len[4*k +: 4]  = len_a[k];
        end
        i_Req   = mask;
        req_cyc = cyc;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            @(posedge i_clk10MHz);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            eng_q.delete();
        end
        repeat (GAP + 15) @(posedge i_clk10MHz);
    endtask

    task automatic round(input logic [N-1:0] mask, input int budget);
        issue_round(mask);
        wait_drain(budget);
    endtask

    // Requesters release on done, or randomly right after being granted.
    initial begin
        forever begin
            @(negedge i_clk10MHz);
            for (int k = 0; k < N; k++)
                if (o_Done[k] || (o_Grant[k] && drop_a[k])) i_Req[k] = 1'b0;
        end
    end

    // Engine model: 0 busy then done, 1 done without busy, 2 silent, 3 hang.
    initial begin
        plan_t p;
        i_Eng_Busy = 1'b0;
        i_Eng_Done = 1'b0;
        i_Eng_Nack = 1'b0;
        forever begin
            @(negedge i_clk10MHz);
            if (o_Start && !i_RST && eng_q.size() != 0) begin
                p = eng_q.pop_front();
                case (p.mode)
                    0: begin
                        repeat (p.bdly + 1) @(posedge i_clk10MHz);
                        #1 i_Eng_Busy = 1'b1;
                        repeat (p.run) @(posedge i_clk10MHz);
                        #1 i_Eng_Done = 1'b1;
                        i_Eng_Nack   = p.nack;
                        eng_done_cyc = cyc;
                        @(posedge i_clk10MHz);
                        #1 i_Eng_Done = 1'b0;
                        i_Eng_Nack = 1'b0;
                        i_Eng_Busy = 1'b0;
                    end
                    1: begin
                        @(posedge i_clk10MHz);
                        #1 i_Eng_Done = 1'b1;
                        i_Eng_Nack   = p.nack;
                        eng_done_cyc = cyc;
                        @(posedge i_clk10MHz);
                        #1 i_Eng_Done = 1'b0;
                        i_Eng_Nack = 1'b0;
                    end
                    3: begin
                        @(posedge i_clk10MHz);
                        #1 i_Eng_Busy = 1'b1;
                        repeat (300) @(posedge i_clk10MHz);
                        #1 i_Eng_Busy = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [N-1:0] pg;
        int gcyc, scyc, acyc, dcyc;
        exp_t e;
        pg = '0;
        gcyc = 0;
        scyc = 0;
        acyc = -100;
        dcyc = -1000;
        forever begin
            @(negedge i_clk10MHz);
            if (i_RST) begin
                pg = '0;
                continue;
            end
            if (o_Grant != 0 && pg == 0) begin
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", o_Grant, 0);
                end else begin
                    e = exp_q[0];
                    check("grant", o_Grant, 1 << e.idx);
                    check("fields", {o_RW, o_Start_Addr, o_Byte_Count},
                          {e.rw, e.addr, e.len});
                    check("gap_min", (cyc - dcyc) >= GAP + 1, 1);
                    if (e.first) check("req_to_grant", cyc - req_cyc, 1);
                    else check("gap_held", cyc - dcyc, GAP + 1);
                end
                gcyc = cyc;
            end
            if (o_Start) begin
                if (exp_q.size() == 0) begin
                    check("start_unexpected", o_Start, 0);
                end else begin
                    e = exp_q[0];
                    check("start_lat", cyc - gcyc, 1);
                    check("start_len0", e.len == 0, 0);
                    check("start_grant", o_Grant, 1 << e.idx);
                end
                scyc = cyc;
            end
            if (o_Abort) begin
                if (exp_q.size() == 0) begin
                    check("abort_unexpected", o_Abort, 0);
                end else begin
                    e = exp_q[0];
                    check("abort_mode", e.mode, 2);
                    check("abort_time", cyc - scyc, TO - 1);
                end
                acyc = cyc;
            end
            if (o_Done != 0 || o_Err != 0) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {o_Done, o_Err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done", o_Done, 1 << e.idx);
                    check("err", o_Err, e.err ? (1 << e.idx) : 0);
                    check("grant_clear", o_Grant, 0);
                    if (e.len == 0) check("len0_lat", cyc - gcyc, 1);
                    else if (e.mode == 2) check("abort_to_done", cyc - acyc, 1);
                    else check("eng_to_done", cyc - eng_done_cyc, 2);
                end
                dcyc = cyc;
            end
            pg = o_Grant;
        end
    end

    initial begin
        #(100 * 95000);
        $display("FAIL global_timeout actual=%0d required<95000 cycles", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        i_RST      = 1'b1;
        i_Req      = '0;
        i_Req_RW   = '0;
        i_Req_Addr = '0;
        i_Req_Len  = '0;
        for (int k = 0; k < N; k++) set_req(k, 0, 8'h00, 4'h1, 0, 0, 1, 0);
        repeat (3) @(posedge i_clk10MHz);
        #1;
        check("reset_state", {o_Grant, o_Start, o_RW, o_Start_Addr,
                              o_Byte_Count, o_Abort, o_Done, o_Err}, 0);
        i_RST = 1'b0;
        repeat (5) @(posedge i_clk10MHz);

        set_req(0, 0, 8'h10, 4'd3, 0, 0, 100, 0);
        round(4'b0001, 2000);

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) rand_req(k);
            for (int k = 0; k < N; k++) begin
                if (len_a[k] == 0) len_a[k] = 4'd2;
                plan_a[k].nack = 1'b0;
            end
            round(4'b1011, 3000);
        end

        for (int k = 0; k < N; k++) rand_req(k);
        round(4'b1001, 3000);
        rand_req(3);
        round(4'b1000, 3000);

        set_req(1, 1, 8'hA5, 4'd7, 0, 2, 10, 1);
        round(4'b0010, 2000);

        set_req(2, 0, 8'h3C, 4'd5, 2, 0, 0, 0);
        round(4'b0100, 60000);

        set_req(3, 1, 8'hFF, 4'd0, 0, 0, 1, 0);
        round(4'b1000, 2000);

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < N; k++) rand_req(k);
            round(4'($urandom_range(1, 15)), 5000);
        end

        set_req(2, 0, 8'h22, 4'd1, 0, 0, 5, 0);
        round(4'b0100, 2000);
        set_req(3, 1, 8'h77, 4'd4, 3, 0, 0, 0);
        issue_round(4'b1000);
        for (int i = 0; i < 200 && !o_Start; i++) @(posedge i_clk10MHz);
        repeat (10) @(posedge i_clk10MHz);
        #3 i_RST = 1'b1;
        exp_q.delete();
        eng_q.delete();
        i_Req    = '0;
        model_rr = 0;
        #1;
        check("reset_mid_run", {o_Grant, o_Start, o_RW, o_Start_Addr,
                                o_Byte_Count, o_Abort, o_Done, o_Err}, 0);
        @(posedge i_clk10MHz);
        #3 i_RST = 1'b0;
        repeat (350) @(posedge i_clk10MHz);
        set_req(0, 1, 8'h5A, 4'd2, 0, 1, 8, 0);
        set_req(3, 0, 8'h81, 4'd9, 1, 0, 0, 1);
        round(4'b1001, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
